result_store_ctrl: RTL and testbench

Sequencing controller for the grayscale/RGB result buffer. It accepts one RGB pixel per handshake from the Sobel output stage and serialises each pixel into three byte writes (R, G, B) on a single-port byte-wide result RAM. It shares that RAM with a host byte-read port through a two-way round-robin arbiter, counts pixels per frame, and signals frame completion.

---
 rtl/result_store_pkg.sv | 18 +
 rtl/result_store_ctrl_arb.sv | 31 +++
 rtl/result_store_ctrl.sv | 169 ++++++++++++++++
 tb/tb_result_store_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/result_store_pkg.sv
// Shared types and constants for the result buffer sequencing controller.
package result_store_pkg;

  localparam int BYTES_PER_PIXEL          = 3;
  localparam int RESULT_ARRAY_LEN_DEFAULT = 51200;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_WR_R,
    S_WR_G,
    S_WR_B,
    S_RD
  } rs_state_t;

endpackage

// File: rtl/result_store_ctrl_arb.sv
// Two-requester round-robin arbiter. req[0] is the pixel stream, req[1] the
// host read port. Only contended grants move the priority pointer, so an
// uncontended requester never costs the other one its turn.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the winner of the last contended grant; resets to "read" so
  // the pixel stream wins the first contention.
  logic last_gnt;

  // Grant the sole requester, or the loser of the last contention.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Remember who won when both were asking.
  always_ff @(posedge clk) begin
    if (rst)                        last_gnt <= 1'b1;
    else if (en && (req == 2'b11))  last_gnt <= gnt[1];
  end

endmodule

// File: rtl/result_store_ctrl.sv
// Result buffer sequencer: serialises each accepted RGB pixel into three
// byte writes on the shared result RAM, interleaves host byte reads through
// a round-robin arbiter, and counts pixels to flag frame completion.
module result_store_ctrl
  import result_store_pkg::*;
#(
  parameter int RESULT_ARRAY_LEN = RESULT_ARRAY_LEN_DEFAULT,
  parameter int NUM_PIXELS       = 17066,
  parameter int ADDR_W           = $clog2(RESULT_ARRAY_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [7:0]        red_i,
  input  logic [7:0]        green_i,
  input  logic [7:0]        blue_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_ack_o,
  output logic              rd_valid_o,
  output logic [7:0]        rd_data_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = $clog2(NUM_PIXELS + 1);

  // A frame must fit in the RAM so the write base never wraps.
  if (BYTES_PER_PIXEL * NUM_PIXELS > RESULT_ARRAY_LEN) begin : g_size_chk
    $error("result_store_ctrl: 3*NUM_PIXELS exceeds RESULT_ARRAY_LEN");
  end

  rs_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, rd_addr_q;
  logic [CNT_W-1:0]  pix_cnt_q;
  byte_t             r_q, g_q, b_q;
  logic              busy_q, done_q, rd_valid_q;

  logic              last_pix;
  logic              arb_en;
  logic [1:0]        arb_req, arb_gnt;
  logic              pix_gnt, rd_gnt;

  // The pixel being written in WR_B is the final one of the frame.
  assign last_pix = (pix_cnt_q == CNT_W'(NUM_PIXELS - 1));

  // Grant points: IDLE (reads only, start has priority), WAIT, and every
  // WR_B except the one closing the frame. Nothing is granted under reset.
  always_comb begin
    arb_en = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE:  arb_en = !start_i;
        S_WAIT:  arb_en = 1'b1;
        S_WR_B:  arb_en = !last_pix;
        default: arb_en = 1'b0;
      endcase
    end
    arb_req = {rd_req_i, pix_valid_i && busy_q && (state_q != S_IDLE)};
  end

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (arb_en),
    .req (arb_req),
    .gnt (arb_gnt)
  );

  assign pix_gnt = arb_gnt[0];
  assign rd_gnt  = arb_gnt[1];

  // Next-state and RAM-side outputs.
  always_comb begin
    state_d     = state_q;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i)     state_d = S_WAIT;
        else if (rd_gnt) state_d = S_RD;
      end
      S_WAIT: begin
        if (pix_gnt)     state_d = S_WR_R;
        else if (rd_gnt) state_d = S_RD;
      end
      S_WR_R: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = base_q;
        mem_wdata_o = r_q;
        state_d     = S_WR_G;
      end
      S_WR_G: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = base_q + ADDR_W'(1);
        mem_wdata_o = g_q;
        state_d     = S_WR_B;
      end
      S_WR_B: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = base_q + ADDR_W'(2);
        mem_wdata_o = b_q;
        if (last_pix)     state_d = S_IDLE;
        else if (pix_gnt) state_d = S_WR_R;
        else if (rd_gnt)  state_d = S_RD;
        else              state_d = S_WAIT;
      end
      S_RD: begin
        mem_addr_o = rd_addr_q;
        state_d    = busy_q ? S_WAIT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pix_ready_o = pix_gnt;
  assign rd_ack_o    = rd_gnt;
  assign rd_valid_o  = rd_valid_q;
  assign rd_data_o   = rd_valid_q ? mem_rdata_i : 8'h00;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

  // State, write base, pixel counter and captured request data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      pix_cnt_q  <= '0;
      rd_addr_q  <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= 1'b0;
      rd_valid_q <= (state_q == S_RD);
      if ((state_q == S_IDLE) && start_i) begin
        base_q    <= '0;
        pix_cnt_q <= '0;
        busy_q    <= 1'b1;
      end
      if (pix_gnt) begin
        r_q <= red_i;
        g_q <= green_i;
        b_q <= blue_i;
      end
      if (rd_gnt) rd_addr_q <= rd_addr_i;
      if (state_q == S_WR_B) begin
        base_q    <= base_q + ADDR_W'(BYTES_PER_PIXEL);
        pix_cnt_q <= pix_cnt_q + CNT_W'(1);
        if (last_pix) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_result_store_ctrl.sv
// Bench for result_store_ctrl: a transaction-level model predicts grants,
// RAM traffic, read returns and frame status every cycle; directed phases
// add hand-computed literal expectations.
module tb_result_store_ctrl;

  localparam int LEN = 64;
  localparam int NP  = 4;
  localparam int AW  = $clog2(LEN);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0, pix_valid_i = 1'b0, rd_req_i = 1'b0;
  logic [7:0]    red_i = '0, green_i = '0, blue_i = '0;
  logic [AW-1:0] rd_addr_i = '0;
  logic          pix_ready_o, rd_ack_o, rd_valid_o, mem_we_o, busy_o, done_o;
  logic [7:0]    rd_data_o, mem_wdata_o, mem_rdata_i;
  logic [AW-1:0] mem_addr_o;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  result_store_ctrl #(.RESULT_ARRAY_LEN(LEN), .NUM_PIXELS(NP)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ack_o(rd_ack_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .busy_o(busy_o), .done_o(done_o)
  );

  // Result RAM: byte wide, one-cycle read latency, cleared with reset.
  logic [7:0] ram [LEN];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < LEN; i++) ram[i] <= 8'h00;
    else if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= ram[mem_addr_o];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  bit         m_busy, m_done, m_rd, m_rdv, m_last_rd;
  int         m_phase, m_cnt, m_rdaddr, cyc;
  logic [7:0] m_pix [3];
  logic [7:0] gold [LEN];

  // Observation logs used by the directed literal checks.
  int wr_a[$], wr_d[$], wr_c[$], gnt_log[$];
  int done_cnt, done_cyc;

  initial begin
    bit idle, wait_st, last, gp, pix_el, rd_el, e_pix, e_rd;
    m_last_rd = 1; cyc = 0; done_cnt = 0; done_cyc = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_busy = 0; m_done = 0; m_rd = 0; m_rdv = 0; m_last_rd = 1;
        m_phase = 0; m_cnt = 0; m_rdaddr = 0;
        for (int i = 0; i < LEN; i++) gold[i] = 8'h00;
        continue;
      end
      // Where the controller is, in model terms.
      idle    = !m_busy && !m_rd && (m_phase == 0);
      wait_st = m_busy && !m_rd && (m_phase == 0);
      last    = (m_phase == 3) && (m_cnt == NP - 1);
      gp      = (idle && !start_i) || wait_st || ((m_phase == 3) && !last);
      pix_el  = gp && m_busy && pix_valid_i;
      rd_el   = gp && rd_req_i;
      e_pix   = pix_el && (!rd_el || m_last_rd);
      e_rd    = rd_el && !e_pix;

      chk("pix_ready", pix_ready_o, e_pix);
      chk("rd_ack", rd_ack_o, e_rd);
      chk("mem_we", mem_we_o, m_phase != 0);
      if (m_phase != 0) begin
        chk("wr_addr", mem_addr_o, 3 * m_cnt + m_phase - 1);
        chk("wr_data", mem_wdata_o, m_pix[m_phase-1]);
      end
      if (m_rd) chk("rd_mem_addr", mem_addr_o, m_rdaddr);
      chk("rd_valid", rd_valid_o, m_rdv);
      chk("rd_data", rd_data_o, m_rdv ? gold[m_rdaddr] : 8'h00);
      chk("busy", busy_o, m_busy);
      chk("done", done_o, m_done);

      if (pix_valid_i && pix_ready_o) gnt_log.push_back(1);
      if (rd_ack_o) gnt_log.push_back(2);
      if (mem_we_o) begin
        wr_a.push_back(int'(mem_addr_o));
        wr_d.push_back(int'(mem_wdata_o));
        wr_c.push_back(cyc);
      end
      if (done_o) begin done_cnt++; done_cyc = cyc; end

      // Advance the model to the next cycle.
      if (m_phase != 0) gold[3 * m_cnt + m_phase - 1] = m_pix[m_phase-1];
      m_rdv  = m_rd;
      m_done = last;
      if (pix_el && rd_el) m_last_rd = e_rd;
      if (e_rd) m_rdaddr = int'(rd_addr_i);
      m_rd = e_rd;
      if (idle && start_i) begin m_busy = 1; m_cnt = 0; end
      if (m_phase == 3) begin
        m_cnt++;
        if (last) m_busy = 0;
      end
      if (e_pix) begin
        m_pix[0] = red_i; m_pix[1] = green_i; m_pix[2] = blue_i;
        m_phase = 1;
      end else if (m_phase == 1 || m_phase == 2) m_phase++;
      else m_phase = 0;
    end
  end

  // ---------------- directed stimulus ----------------
  logic [23:0] tab [12] = '{24'h102030, 24'h405060, 24'h718293, 24'hA4B5C6,
                            24'hD7E8F9, 24'h11_22_33, 24'h44_55_66, 24'h77_88_99,
                            24'hAA_BB_CC, 24'h01_02_03, 24'h0A_0B_0C, 24'hF0_E0_D0};

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one pixel until accepted or the bound runs out.
  task automatic send_pix(input logic [23:0] px, input int bound, output bit ok);
    {red_i, green_i, blue_i} = px;
    pix_valid_i = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < bound && !ok; w++) begin
      #1; ok = pix_ready_o;
      @(posedge clk); #1;
    end
    pix_valid_i = 1'b0;
  endtask

  initial begin
    bit ok, hp, ha;
    int w0, npx, nrd, base_i;

    // Reset state.
    tick(3);
    rst = 1'b0; #1;
    chk("rst_pix_ready", pix_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_mem_we", mem_we_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    tick(1);

    // Frame of 4 pixels streamed back to back, then a 5th that must stall.
    start_i = 1'b1; tick(1); start_i = 1'b0;
    done_cnt = 0;
    w0 = wr_a.size();
    for (int p = 0; p < 4; p++) begin
      send_pix(tab[p], 20, ok);
      chk("frame_pix_accepted", ok, 1);
    end
    send_pix(tab[4], 20, ok);
    chk("pix5_stalls", ok, 0);
    chk("frame_writes", wr_a.size() - w0, 12);
    for (int i = 0; i < 6; i++) begin
      chk("first_wr_addr", wr_a[w0 + i], i);
      chk("first_wr_cycle", wr_c[w0 + i], wr_c[w0] + i);
    end
    chk("wr_d0", wr_d[w0 + 0], 'h10);
    chk("wr_d1", wr_d[w0 + 1], 'h20);
    chk("wr_d2", wr_d[w0 + 2], 'h30);
    chk("wr_d3", wr_d[w0 + 3], 'h40);
    chk("wr_d4", wr_d[w0 + 4], 'h50);
    chk("wr_d5", wr_d[w0 + 5], 'h60);
    chk("last_wr_addr", wr_a[w0 + 11], 11);
    chk("done_pulses", done_cnt, 1);
    chk("done_after_last_wr", done_cyc, wr_c[w0 + 11] + 1);
    chk("busy_after_frame", busy_o, 0);

    // Host read in IDLE: addr 4 holds pixel 1's green byte.
    rd_req_i = 1'b1; rd_addr_i = AW'(4); #1;
    chk("idle_rd_ack", rd_ack_o, 1);
    tick(1); rd_req_i = 1'b0;
    tick(1);
    chk("idle_rd_valid", rd_valid_o, 1);
    chk("idle_rd_data", rd_data_o, 'h50);
    tick(2);

    // Contention: start and read together (start wins), then pixel and read
    // held together alternate grants.
    gnt_log.delete();
    start_i = 1'b1; rd_req_i = 1'b1; rd_addr_i = '0;
    pix_valid_i = 1'b1; {red_i, green_i, blue_i} = tab[4]; #1;
    chk("start_beats_read", rd_ack_o, 0);
    tick(1); start_i = 1'b0;
    npx = 0; nrd = 0;
    for (int c = 0; c < 60 && npx < 4; c++) begin
      #1; hp = pix_ready_o; ha = rd_ack_o;
      @(posedge clk); #1;
      if (hp) begin npx++; {red_i, green_i, blue_i} = tab[4 + npx]; end
      if (ha) begin nrd++; rd_addr_i = AW'(nrd); end
    end
    pix_valid_i = 1'b0;
    chk("contend_pixels", npx, 4);
    tick(4); rd_req_i = 1'b0; tick(3);
    chk("grant_order_0", gnt_log[0], 1);
    chk("grant_order_1", gnt_log[1], 2);
    chk("grant_order_2", gnt_log[2], 1);
    chk("grant_order_3", gnt_log[3], 2);

    // Reset during WR_G aborts the frame with no B write.
    start_i = 1'b1; tick(1); start_i = 1'b0;
    send_pix(tab[8], 20, ok);
    chk("abort_pix_accepted", ok, 1);
    tick(1);
    rst = 1'b1; tick(1); rst = 1'b0; #1;
    chk("abort_pix_ready", pix_ready_o, 0);
    chk("abort_rd_ack", rd_ack_o, 0);
    chk("abort_rd_valid", rd_valid_o, 0);
    chk("abort_rd_data", rd_data_o, 0);
    chk("abort_mem_we", mem_we_o, 0);
    chk("abort_mem_addr", mem_addr_o, 0);
    chk("abort_mem_wdata", mem_wdata_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    tick(1);
    start_i = 1'b1; tick(1); start_i = 1'b0;
    w0 = wr_a.size();
    send_pix(tab[9], 20, ok);
    tick(1);
    chk("restart_wr_addr", wr_a[w0], 0);
    chk("restart_wr_data", wr_d[w0], 'h01);

    // start pulsed while busy must not rewind base or count.
    tick(3);
    start_i = 1'b1; tick(4); start_i = 1'b0;
    base_i = wr_a.size();
    send_pix(tab[10], 20, ok);
    chk("busy_start_pix_accepted", ok, 1);
    tick(1);
    chk("busy_start_wr_addr", wr_a[base_i], 3);
    chk("busy_start_wr_data", wr_d[base_i], 'h0A);
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
